// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with optional skid entry
//
// Purpose:
//   Inter-stage pipeline register with a valid/ready handshake. With DEPTH=2 a
//   skid entry sits behind the head so in_ready comes straight from a flop. With
//   DEPTH=1 it is a single register and in_ready is combinational. A flush squashes
//   all held entries and the incoming beat. Whenever the stage holds nothing,
//   out_ctrl shows CTRL_NOP so that a bubble never asserts a downstream write enable.
//   A saturating counter records cycles where the head is stalled by downstream.
//
// Ports:
//   CLK, nRST              clock (rising edge), asynchronous active-low reset
//   flush                  synchronous squash of held entries and the incoming beat
//   in_valid/in_ready      upstream handshake; in_data/in_ctrl are the upstream beat
//   out_valid/out_ready    downstream handshake; out_data/out_ctrl are the head entry
//   occupancy              number of valid entries held (0..DEPTH)
//   stall_clr/stall_cnt    clear and value of the stalled-head cycle counter

module pipe_stage_elastic #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 DEPTH    = 2,
    parameter int                 STALL_W  = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [CTRL_W-1:0]   in_ctrl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [1:0]          occupancy,
    input  logic                stall_clr,
    output logic [STALL_W-1:0]  stall_cnt
);

    // Encoding equals the number of held entries, so occupancy reads it directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic                load_skid;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                accept;
    logic                pop;

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        load_skid   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (accept) begin
                    // Only reachable with a skid entry: single-register in_ready
                    // is low whenever the head is held.
                    if (DEPTH == 2) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything; main keeps its data so out_data holds.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            load_skid   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_NOP;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    generate
        if (DEPTH == 2) begin : g_skid
            logic in_ready_q;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= CTRL_NOP;
                    in_ready_q  <= 1'b1;
                end else begin
                    if (load_skid) begin
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                    end
                    // Registered ready: low exactly when the next state is full.
                    in_ready_q <= (state_d != TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_load_skid;

            assign unused_load_skid = load_skid;
            assign skid_data_q      = '0;
            assign skid_ctrl_q      = CTRL_NOP;
            assign in_ready         = !out_valid | out_ready;
        end
    endgenerate

    // Clear beats increment; saturate at all-ones; flush leaves the count alone.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_NOP;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule
